// File: rtl/prog_mem_load_ctrl_if.sv
// Bundle of loader, CPU fetch and ProgramMemory signals around prog_mem_load_ctrl.
interface prog_mem_load_ctrl_if #(
   parameter int ADDR_W = 5
);
   logic              ld_start;
   logic              ld_valid;
   logic [31:0]       ld_data;
   logic              ld_last;
   logic              ld_ready;
   logic              clr_req;
   logic [31:0]       cpu_pc;
   logic [31:0]       cpu_instr;
   logic              cpu_stall;
   logic [31:0]       mem_addr;
   logic              mem_write;
   logic              mem_read;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              load_done;
   logic [ADDR_W:0]   load_count;
   logic              err_ovf;

   modport slave (
      input  ld_start, ld_valid, ld_data, ld_last, clr_req, cpu_pc, mem_rdata,
      output ld_ready, cpu_instr, cpu_stall, mem_addr, mem_write, mem_read,
             mem_wdata, load_done, load_count, err_ovf
   );

   modport master (
      output ld_start, ld_valid, ld_data, ld_last, clr_req, cpu_pc, mem_rdata,
      input  ld_ready, cpu_instr, cpu_stall, mem_addr, mem_write, mem_read,
             mem_wdata, load_done, load_count, err_ovf
   );
endinterface

// File: rtl/prog_mem_load_ctrl.sv
// Program memory sequencer: NOP clear, word-by-word load, then CPU fetch release.
//
//   state   | meaning
//   S_CLEAR | writing NOP_WORD to addresses 0..DEPTH-1, CPU stalled
//   S_IDLE  | memory quiet, CPU stalled, waiting for clear or load request
//   S_LOAD  | accepting loader words, one write per accepted beat
//   S_RUN   | CPU fetches through combinational read path
module prog_mem_load_ctrl #(
   parameter int          DEPTH    = 32,
   parameter int          ADDR_W   = 5,
   parameter logic [31:0] NOP_WORD = 32'hF800_0000
) (
   input logic                 clk,
   input logic                 rst_n,
   prog_mem_load_ctrl_if.slave bus
);

   typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LOAD, S_RUN} state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] clr_ptr;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              mem_write_q;
   logic [31:0]       mem_wdata_q;
   logic              load_done_q;
   logic [ADDR_W:0]   load_count_q;
   logic              err_ovf_q;

   logic              accept;
   logic              sess_end;
   logic              fetch;
   logic              pc_ok;

   assign accept   = (state == S_LOAD) && bus.ld_valid;
   assign sess_end = accept && (bus.ld_last || (wr_ptr == LAST_IDX));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_CLEAR;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_CLEAR: if (clr_ptr == LAST_IDX) state_nxt = S_IDLE;
         S_IDLE,
         S_RUN: begin
            if (bus.clr_req)       state_nxt = S_CLEAR;
            else if (bus.ld_start) state_nxt = S_LOAD;
         end
         S_LOAD:  if (sess_end) state_nxt = S_RUN;
         default: state_nxt = S_CLEAR;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_ptr      <= '0;
         wr_ptr       <= '0;
         mem_addr_q   <= '0;
         mem_write_q  <= 1'b0;
         mem_wdata_q  <= NOP_WORD;
         load_done_q  <= 1'b0;
         load_count_q <= '0;
         err_ovf_q    <= 1'b0;
      end else begin
         mem_write_q <= 1'b0;
         load_done_q <= 1'b0;
         case (state)
            S_CLEAR: begin
               mem_write_q <= 1'b1;
               mem_addr_q  <= clr_ptr;
               mem_wdata_q <= NOP_WORD;
               clr_ptr     <= clr_ptr + 1'b1;
            end
            S_IDLE,
            S_RUN: begin
               if (bus.clr_req) begin
                  clr_ptr <= '0;
               end else if (bus.ld_start) begin
                  wr_ptr       <= '0;
                  load_count_q <= '0;
                  err_ovf_q    <= 1'b0;
               end
            end
            S_LOAD: begin
               if (accept) begin
                  mem_write_q  <= 1'b1;
                  mem_addr_q   <= wr_ptr;
                  mem_wdata_q  <= bus.ld_data;
                  wr_ptr       <= wr_ptr + 1'b1;
                  load_count_q <= load_count_q + 1'b1;
                  if (sess_end) begin
                     load_done_q <= 1'b1;
                     err_ovf_q   <= ~bus.ld_last;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // The final load write lands in the first RUN cycle; it owns the address bus
   // and the CPU is held for that one cycle.
   assign fetch = (state == S_RUN) && !mem_write_q;
   assign pc_ok = (bus.cpu_pc[31:ADDR_W+2] == '0) && (bus.cpu_pc[1:0] == 2'b00);

   always_comb begin
      bus.ld_ready  = (state == S_LOAD);
      bus.mem_read  = fetch;
      bus.mem_addr  = fetch ? {{(32-ADDR_W){1'b0}}, bus.cpu_pc[ADDR_W+1:2]}
                            : {{(32-ADDR_W){1'b0}}, mem_addr_q};
      bus.cpu_stall = !fetch || bus.clr_req || bus.ld_start;
      bus.cpu_instr = (fetch && pc_ok) ? bus.mem_rdata : NOP_WORD;
   end

   assign bus.mem_write  = mem_write_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.load_done  = load_done_q;
   assign bus.load_count = load_count_q;
   assign bus.err_ovf    = err_ovf_q;

endmodule

// File: tb/tb_prog_mem_load_ctrl.sv
// Scoreboard bench for prog_mem_load_ctrl: expected memory writes are queued by the
// stimulus and popped by a negedge monitor; status outputs are checked directly.
module tb_prog_mem_load_ctrl;

   localparam logic [31:0] NOP = 32'hF800_0000;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   prog_mem_load_ctrl_if #(.ADDR_W(5)) ifc ();

   prog_mem_load_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   always #5 clk = ~clk;

   logic [31:0] tb_mem [32];
   assign ifc.mem_rdata = tb_mem[ifc.mem_addr[4:0]];
   always @(negedge clk) if (ifc.mem_write) tb_mem[ifc.mem_addr[4:0]] <= ifc.mem_wdata;

   wr_t exp_q[$];
   int  checks = 0;
   int  passes = 0;
   int  done_cnt = 0;

   always @(negedge clk) begin
      wr_t e;
      if (rst_n && ifc.load_done) done_cnt++;
      if (rst_n && ifc.mem_write) begin
         checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_write: addr=%0d data=%h, no write was expected",
                     ifc.mem_addr, ifc.mem_wdata);
         end else begin
            e = exp_q.pop_front();
            if (ifc.mem_addr == {27'd0, e.addr} && ifc.mem_wdata == e.data)
               passes++;
            else
               $display("FAIL mem_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                        ifc.mem_addr, ifc.mem_wdata, e.addr, e.data);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h, expected %h", nm, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_wr(input int a, input logic [31:0] d);
      wr_t e;
      e.addr = 5'(a);
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic push_clear();
      for (int i = 0; i < 32; i++) push_wr(i, NOP);
   endtask

   task automatic wait_drain(input string nm);
      for (int k = 0; k < 80; k++) begin
         if (exp_q.size() == 0) break;
         tick(1);
      end
      chk(nm, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic pulse_start();
      ifc.ld_start = 1'b1;
      tick(1);
      ifc.ld_start = 1'b0;
   endtask

   task automatic send(input logic [31:0] d, input logic last, output bit acc);
      ifc.ld_valid = 1'b1;
      ifc.ld_data  = d;
      ifc.ld_last  = last;
      acc = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (ifc.ld_ready) begin
            acc = 1'b1;
            break;
         end
      end
      tick(1);
      ifc.ld_valid = 1'b0;
      ifc.ld_last  = 1'b0;
   endtask

   logic [31:0] prog [3];
   bit          acc;
   int          d0;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      prog[0] = 32'h2008_0005;
      prog[1] = 32'h2009_0003;
      prog[2] = 32'h0109_5020;
      ifc.ld_start = 1'b0;
      ifc.ld_valid = 1'b0;
      ifc.ld_data  = '0;
      ifc.ld_last  = 1'b0;
      ifc.clr_req  = 1'b0;
      ifc.cpu_pc   = '0;

      // reset state
      tick(2);
      chk("rst_mem_write", {31'd0, ifc.mem_write}, 32'd0);
      chk("rst_mem_read",  {31'd0, ifc.mem_read},  32'd0);
      chk("rst_mem_addr",  ifc.mem_addr, 32'd0);
      chk("rst_mem_wdata", ifc.mem_wdata, NOP);
      chk("rst_cpu_stall", {31'd0, ifc.cpu_stall}, 32'd1);
      chk("rst_ld_ready",  {31'd0, ifc.ld_ready}, 32'd0);
      chk("rst_load_count", {26'd0, ifc.load_count}, 32'd0);
      chk("rst_err_ovf",   {31'd0, ifc.err_ovf}, 32'd0);
      chk("rst_cpu_instr", ifc.cpu_instr, NOP);

      // 1: clear sweep after reset
      push_clear();
      rst_n = 1'b1;
      wait_drain("clear_drain");
      tick(2);
      chk("idle_stall", {31'd0, ifc.cpu_stall}, 32'd1);
      chk("idle_ready", {31'd0, ifc.ld_ready}, 32'd0);
      chk("idle_write", {31'd0, ifc.mem_write}, 32'd0);

      // 2: three-word load back to back
      d0 = done_cnt;
      pulse_start();
      for (int i = 0; i < 3; i++) begin
         push_wr(i, prog[i]);
         send(prog[i], i == 2, acc);
         chk("load2_accept", {31'd0, acc}, 32'd1);
      end
      tick(2);
      chk("load2_drain", 32'(exp_q.size()), 32'd0);
      chk("load2_done_pulses", 32'(done_cnt - d0), 32'd1);
      chk("load2_count", {26'd0, ifc.load_count}, 32'd3);
      chk("load2_err", {31'd0, ifc.err_ovf}, 32'd0);
      chk("load2_stall", {31'd0, ifc.cpu_stall}, 32'd0);
      chk("load2_instr_pc0", ifc.cpu_instr, 32'h2008_0005);
      chk("load2_mem2", tb_mem[2], 32'h0109_5020);

      // 3: same load, valid toggling
      d0 = done_cnt;
      pulse_start();
      for (int i = 0; i < 3; i++) begin
         push_wr(i, prog[i]);
         send(prog[i], i == 2, acc);
         chk("load3_accept", {31'd0, acc}, 32'd1);
         tick(1);
      end
      tick(1);
      chk("load3_drain", 32'(exp_q.size()), 32'd0);
      chk("load3_done_pulses", 32'(done_cnt - d0), 32'd1);
      chk("load3_count", {26'd0, ifc.load_count}, 32'd3);

      // 4: overflow, 33 words without last
      d0 = done_cnt;
      pulse_start();
      for (int i = 0; i < 33; i++) begin
         if (i < 32) push_wr(i, 32'hA000_0000 + 32'(i));
         send(32'hA000_0000 + 32'(i), 1'b0, acc);
         chk("ovf_accept", {31'd0, acc}, (i < 32) ? 32'd1 : 32'd0);
      end
      tick(1);
      chk("ovf_drain", 32'(exp_q.size()), 32'd0);
      chk("ovf_err", {31'd0, ifc.err_ovf}, 32'd1);
      chk("ovf_count", {26'd0, ifc.load_count}, 32'd32);
      chk("ovf_ready", {31'd0, ifc.ld_ready}, 32'd0);
      chk("ovf_done_pulses", 32'(done_cnt - d0), 32'd1);
      chk("ovf_run_stall", {31'd0, ifc.cpu_stall}, 32'd0);

      // 5: fetch path
      ifc.cpu_pc = 32'h8;  #1 chk("fetch_pc8", ifc.cpu_instr, 32'hA000_0002);
      ifc.cpu_pc = 32'h7C; #1 chk("fetch_pc7c", ifc.cpu_instr, 32'hA000_001F);
      ifc.cpu_pc = 32'h80; #1 chk("fetch_pc80", ifc.cpu_instr, NOP);
      ifc.cpu_pc = 32'h6;  #1 chk("fetch_pc6", ifc.cpu_instr, NOP);
      ifc.cpu_pc = 32'h0;
      tick(1);

      // 6: clear beats load, then reset mid-load
      push_clear();
      ifc.clr_req  = 1'b1;
      ifc.ld_start = 1'b1;
      #1 chk("req_stall_same_cycle", {31'd0, ifc.cpu_stall}, 32'd1);
      tick(1);
      ifc.clr_req  = 1'b0;
      ifc.ld_start = 1'b0;
      chk("clr_wins_ready", {31'd0, ifc.ld_ready}, 32'd0);
      wait_drain("clr_req_drain");
      chk("clr_mem5", tb_mem[5], NOP);

      pulse_start();
      for (int i = 0; i < 2; i++) begin
         push_wr(i, prog[i]);
         send(prog[i], 1'b0, acc);
         chk("midload_accept", {31'd0, acc}, 32'd1);
      end
      tick(1);
      chk("midload_drain", 32'(exp_q.size()), 32'd0);
      chk("midload_mem1", tb_mem[1], 32'h2009_0003);
      rst_n = 1'b0;
      #1;
      chk("midrst_count", {26'd0, ifc.load_count}, 32'd0);
      chk("midrst_stall", {31'd0, ifc.cpu_stall}, 32'd1);
      chk("midrst_ready", {31'd0, ifc.ld_ready}, 32'd0);
      tick(2);
      push_clear();
      rst_n = 1'b1;
      wait_drain("rst_clear_drain");
      chk("rst_clear_mem0", tb_mem[0], NOP);
      chk("rst_clear_mem1", tb_mem[1], NOP);
      tick(2);
      chk("final_stall", {31'd0, ifc.cpu_stall}, 32'd1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
